vram_sprite_line_store: RTL and testbench

Parametrised banked sprite-line memory for the sprite pipeline. The CPU-side write port accepts individual pixel-pair words through a small write FIFO with a valid/ready handshake. The sprite fetcher reads one full sprite line (all banks in parallel) per cycle with fixed 2-cycle latency. An optional clear engine zeroes the whole store in hardware.

---
 rtl/vram_sprite_line_store_if.sv | 29 ++
 rtl/vram_sprite_line_store.sv | 182 ++++++++++++++++++
 tb/tb_vram_sprite_line_store.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_sprite_line_store_if.sv
// Write/read bus of the sprite line store: CPU write handshake plus sprite-fetcher line read.
interface vram_sprite_line_store_if #(
  parameter int BANKS  = 8,
  parameter int WORD_W = 16,
  parameter int LINES  = 4096
);
  localparam int AW = $clog2(LINES * BANKS);
  localparam int LW = $clog2(LINES);

  logic                    wr_valid;
  logic                    wr_ready;
  logic [AW-1:0]           wr_addr;
  logic [WORD_W-1:0]       wr_data;
  logic                    wr_idle;
  logic                    rd_en;
  logic [LW-1:0]           rd_addr;
  logic                    rd_valid;
  logic [BANKS*WORD_W-1:0] rd_data;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_en, rd_addr,
    input  wr_ready, wr_idle, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_en, rd_addr,
    output wr_ready, wr_idle, rd_valid, rd_data
  );
endinterface

// File: rtl/vram_sprite_line_store.sv
// Banked sprite-line store: write FIFO into BANKS RAMs, full-line reads with 2-cycle latency.
// Optional hardware clear engine enabled by defining VRAM_CLEAR_EN.
module vram_sprite_line_store_bank #(
  parameter  int WORD_W = 16,
  parameter  int LINES  = 4096,
  localparam int LW     = $clog2(LINES)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [LW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [LINES];
  logic [WORD_W-1:0] rdata_q;

  // Read-first: a same-edge write is not visible to the read.
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = rdata_q;
endmodule

module vram_sprite_line_store #(
  parameter int BANKS      = 8,
  parameter int WORD_W     = 16,
  parameter int LINES      = 4096,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
`ifdef VRAM_CLEAR_EN
  input  logic clear_start,
  output logic clear_busy,
`endif
  vram_sprite_line_store_if.slave bus
);
  localparam int BW        = $clog2(BANKS);
  localparam int LW        = $clog2(LINES);
  localparam int AW        = LW + BW;
  localparam int PW        = $clog2(FIFO_DEPTH);
  localparam int RD_STAGES = 1;

  logic [FIFO_DEPTH-1:0][AW-1:0]     fifo_addr_q, fifo_addr_d;
  logic [FIFO_DEPTH-1:0][WORD_W-1:0] fifo_data_q, fifo_data_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic fifo_full, fifo_empty, push, pop, is_idle, clearing;
  logic [LW-1:0] clr_line;

  assign fifo_full    = count_q == (PW+1)'(FIFO_DEPTH);
  assign fifo_empty   = count_q == '0;
  assign bus.wr_ready = !fifo_full && is_idle;
  assign bus.wr_idle  = fifo_empty && is_idle;
  assign push         = bus.wr_valid && bus.wr_ready;
  assign pop          = !fifo_empty && !clearing;

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      fifo_addr_d[wr_ptr_q] = bus.wr_addr;
      fifo_data_d[wr_ptr_q] = bus.wr_data;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + (PW+1)'(1);
    else if (!push && pop) count_d = count_q - (PW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

`ifdef VRAM_CLEAR_EN
  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_e;
  state_e        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;

  // A word pushed on the clear_start edge must still drain before clearing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  if (clear_start) state_d = (!fifo_empty || push) ? DRAIN : CLEAR;
      DRAIN: if (fifo_empty) state_d = CLEAR;
      CLEAR: begin
        cnt_d = cnt_q + LW'(1);
        if (cnt_q == LW'(LINES - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign is_idle    = state_q == IDLE;
  assign clearing   = state_q == CLEAR;
  assign clr_line   = cnt_q;
  assign clear_busy = !is_idle;
`else
  assign is_idle  = 1'b1;
  assign clearing = 1'b0;
  assign clr_line = '0;
`endif

  logic [AW-1:0]                head_addr;
  logic [WORD_W-1:0]            head_data, mem_wdata;
  logic [LW-1:0]                mem_waddr;
  logic [BW-1:0]                head_bank;
  logic [BANKS-1:0]             bank_we;
  logic [BANKS-1:0][WORD_W-1:0] bank_rdata;

  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];
  assign head_bank = head_addr[BW-1:0];
  assign mem_waddr = clearing ? clr_line : head_addr[AW-1:BW];
  assign mem_wdata = clearing ? '0 : head_data;

  // Writes are suppressed on the reset edge so an interrupted clear or queued word stops cleanly.
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    assign bank_we[b] = !reset && (clearing || (pop && head_bank == BW'(b)));
    vram_sprite_line_store_bank #(.WORD_W(WORD_W), .LINES(LINES)) u_bank (
      .clk   (clk),
      .we    (bank_we[b]),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .re    (bus.rd_en),
      .raddr (bus.rd_addr),
      .rdata (bank_rdata[b])
    );
  end

  logic [RD_STAGES:0]      vld_pipe_q, vld_pipe_d;
  logic [BANKS*WORD_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    vld_pipe_d = {vld_pipe_q[RD_STAGES-1:0], bus.rd_en};
    rd_data_d  = vld_pipe_q[RD_STAGES-1] ? bank_rdata : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      rd_data_q  <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.rd_valid = vld_pipe_q[RD_STAGES];
  assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_vram_sprite_line_store.sv
// Randomized self-checking bench for vram_sprite_line_store against a word-array reference model.
module tb_vram_sprite_line_store;
  localparam int BANKS = 8, WORD_W = 16, LINES = 256, FIFO_DEPTH = 4;
  localparam int LW = $clog2(LINES), AW = $clog2(LINES * BANKS), DW = BANKS * WORD_W;
  typedef logic [DW-1:0] dw_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vram_sprite_line_store_if #(.BANKS(BANKS), .WORD_W(WORD_W), .LINES(LINES)) bus ();

`ifdef VRAM_CLEAR_EN
  logic clear_start = 1'b0;
  logic clear_busy;
`endif

  vram_sprite_line_store #(.BANKS(BANKS), .WORD_W(WORD_W), .LINES(LINES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef VRAM_CLEAR_EN
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
`endif
    .bus         (bus)
  );

  logic [WORD_W-1:0] ref_mem [LINES][BANKS];
  dw_t exp_rd;
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input dw_t got, input dw_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic dw_t model_line(input int ln);
    dw_t v;
    for (int b = 0; b < BANKS; b++) v[b*WORD_W +: WORD_W] = ref_mem[ln][b];
    return v;
  endfunction

  // Leaves wr_valid high; caller drops it when the burst ends.
  task automatic push_word(input int addr, input logic [WORD_W-1:0] data, input bit check_ready);
    int guard = 0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(addr);
    bus.wr_data  = data;
    if (check_ready) chk("wr_ready_stream", dw_t'(bus.wr_ready), dw_t'(1));
    while (!bus.wr_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) chk("wr_ready_timeout", dw_t'(0), dw_t'(1));
    tick();
    ref_mem[addr / BANKS][addr % BANKS] = data;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (!bus.wr_idle && guard < 4 * LINES) begin
      tick();
      guard++;
    end
    chk("wr_idle", dw_t'(bus.wr_idle), dw_t'(1));
  endtask

  // rd_en sampled at an edge gives rd_valid one edge later; rd_data holds otherwise.
  task automatic read_seq(input int q[$], input bit gaps);
    bit prev_en = 1'b0;
    int prev_line = 0;
    int i = 0;
    forever begin
      bit en = 1'b0;
      int ln = 0;
      if (i < q.size() && (!gaps || $urandom_range(0, 2) != 0)) begin
        en = 1'b1;
        ln = q[i];
        i++;
      end
      bus.rd_en   = en;
      bus.rd_addr = LW'(ln);
      tick();
      chk("rd_valid", dw_t'(bus.rd_valid), dw_t'(prev_en));
      if (prev_en) exp_rd = model_line(prev_line);
      chk("rd_data", bus.rd_data, exp_rd);
      prev_en   = en;
      prev_line = ln;
      if (i >= q.size() && !en) break;
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic fill_all();
    for (int a = 0; a < LINES * BANKS; a++) push_word(a, WORD_W'($urandom), 1'b0);
    bus.wr_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    int q[$];
    int x_addr;
    dw_t old_line;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_en    = 1'b0;
    bus.rd_addr  = '0;
    exp_rd       = '0;

    tick();
    tick();
    chk("rst_wr_ready", dw_t'(bus.wr_ready), dw_t'(1));
    chk("rst_wr_idle", dw_t'(bus.wr_idle), dw_t'(1));
    chk("rst_rd_valid", dw_t'(bus.rd_valid), dw_t'(0));
    chk("rst_rd_data", bus.rd_data, dw_t'(0));
`ifdef VRAM_CLEAR_EN
    chk("rst_clear_busy", dw_t'(clear_busy), dw_t'(0));
`endif
    reset = 1'b0;

    fill_all();

    // Single word to bank 1, line 1
    push_word(9, 16'hA5A5, 1'b0);
    bus.wr_valid = 1'b0;
    wait_idle();
    read_seq('{1}, 1'b0);
    chk("a5a5_field", dw_t'(bus.rd_data[31:16]), dw_t'(16'hA5A5));

    // Ten words back to back: ready must never drop
    q = {};
    for (int k = 0; k < 10; k++) begin
      int a = $urandom_range(0, LINES * BANKS - 1);
      push_word(a, WORD_W'($urandom), 1'b1);
      q.push_back(a / BANKS);
    end
    bus.wr_valid = 1'b0;
    wait_idle();
    read_seq(q, 1'b0);

    // Back-to-back lines 0..7
    read_seq('{0, 1, 2, 3, 4, 5, 6, 7}, 1'b0);

    // Read-first collision on line 3 bank 0
    push_word(24, 16'hBEEF, 1'b0);
    bus.wr_valid = 1'b0;
    wait_idle();
    old_line     = model_line(3);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(24);
    bus.wr_data  = 16'h1234;
    tick();
    bus.wr_valid = 1'b0;
    bus.rd_en    = 1'b1;
    bus.rd_addr  = LW'(3);
    tick();
    tick();
    bus.rd_en = 1'b0;
    chk("rf_valid", dw_t'(bus.rd_valid), dw_t'(1));
    chk("rf_old", bus.rd_data, old_line);
    ref_mem[3][0] = 16'h1234;
    tick();
    exp_rd = model_line(3);
    chk("rf_new", bus.rd_data, exp_rd);
    chk("rf_new_bank0", dw_t'(bus.rd_data[15:0]), dw_t'(16'h1234));
    tick();

    // Reset right after acceptance discards the queued word
    x_addr       = $urandom_range(0, LINES * BANKS - 1);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(x_addr);
    bus.wr_data  = ~ref_mem[x_addr / BANKS][x_addr % BANKS];
    tick();
    bus.wr_valid = 1'b0;
    reset        = 1'b1;
    tick();
    reset  = 1'b0;
    exp_rd = '0;
    chk("rstq_wr_idle", dw_t'(bus.wr_idle), dw_t'(1));
    chk("rstq_rd_data", bus.rd_data, dw_t'(0));
    read_seq('{x_addr / BANKS}, 1'b0);

    // Random rounds: gapped writes, then gapped reads
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 30; k++) begin
        if ($urandom_range(0, 1) != 0) begin
          bus.wr_valid = 1'b0;
          tick();
        end
        push_word($urandom_range(0, LINES * BANKS - 1), WORD_W'($urandom), 1'b0);
      end
      bus.wr_valid = 1'b0;
      wait_idle();
      q = {};
      for (int k = 0; k < 20; k++) q.push_back($urandom_range(0, LINES - 1));
      read_seq(q, 1'b1);
    end

`ifdef VRAM_CLEAR_EN
    begin
      int busy;
      int guard;
      bit ready_bad;

      // One queued word: one DRAIN cycle, then LINES CLEAR cycles
      push_word($urandom_range(0, LINES * BANKS - 1), 16'h5A5A, 1'b0);
      bus.wr_valid = 1'b0;
      clear_start  = 1'b1;
      tick();
      clear_start = 1'b0;
      chk("drain_busy", dw_t'(clear_busy), dw_t'(1));
      chk("drain_idle_low", dw_t'(bus.wr_idle), dw_t'(0));
      busy = 1; guard = 0; ready_bad = 1'b0;
      if (bus.wr_ready) ready_bad = 1'b1;
      while (clear_busy && guard < 2 * LINES) begin
        tick();
        if (clear_busy) begin
          busy++;
          if (bus.wr_ready) ready_bad = 1'b1;
        end
        guard++;
      end
      chk("drain_clear_len", dw_t'(busy), dw_t'(LINES + 1));
      chk("drain_ready_low", dw_t'(ready_bad), dw_t'(0));
      for (int l = 0; l < LINES; l++) for (int b = 0; b < BANKS; b++) ref_mem[l][b] = '0;
      q = {};
      for (int l = 0; l < LINES; l++) q.push_back(l);
      read_seq(q, 1'b0);

      // Empty FIFO clear; a second clear_start mid-clear is ignored
      for (int k = 0; k < 20; k++)
        push_word($urandom_range(0, LINES * BANKS - 1), WORD_W'($urandom) | 16'h1, 1'b0);
      bus.wr_valid = 1'b0;
      wait_idle();
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      chk("clr_busy", dw_t'(clear_busy), dw_t'(1));
      chk("clr_ready_low", dw_t'(bus.wr_ready), dw_t'(0));
      busy = 1; guard = 0; ready_bad = 1'b0;
      while (clear_busy && guard < 2 * LINES) begin
        if (guard == 10) clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        if (clear_busy) begin
          busy++;
          if (bus.wr_ready) ready_bad = 1'b1;
        end
        guard++;
      end
      chk("clr_len", dw_t'(busy), dw_t'(LINES));
      chk("clr_ready_bad", dw_t'(ready_bad), dw_t'(0));
      chk("clr_ready_after", dw_t'(bus.wr_ready), dw_t'(1));
      for (int l = 0; l < LINES; l++) for (int b = 0; b < BANKS; b++) ref_mem[l][b] = '0;
      read_seq(q, 1'b0);

      // Reset while the clear is at line 100
      fill_all();
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      for (int k = 0; k < 100; k++) tick();
      reset = 1'b1;
      tick();
      reset  = 1'b0;
      exp_rd = '0;
      chk("rstc_clear_busy", dw_t'(clear_busy), dw_t'(0));
      chk("rstc_wr_ready", dw_t'(bus.wr_ready), dw_t'(1));
      chk("rstc_wr_idle", dw_t'(bus.wr_idle), dw_t'(1));
      chk("rstc_rd_valid", dw_t'(bus.rd_valid), dw_t'(0));
      chk("rstc_rd_data", bus.rd_data, dw_t'(0));
      for (int l = 0; l < 100; l++) for (int b = 0; b < BANKS; b++) ref_mem[l][b] = '0;
      read_seq(q, 1'b0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
